// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one ALU operation per request (optionally with OPA sent ahead of OPB),
// waits the ALU latency in CE-high edges, captures RES and flags, and returns them on a valid/ready port.
module alu_op_sequencer #(
   parameter int WIDTH   = 8,
   parameter int LAT     = 1,
   parameter int MUL_LAT = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               CE,
   input  logic               REQ_VALID,
   output logic               REQ_READY,
   input  logic               REQ_MODE,
   input  logic [3:0]         REQ_CMD,
   input  logic [1:0]         REQ_IV,
   input  logic [3:0]         REQ_GAP,
   input  logic [WIDTH-1:0]   REQ_OPA,
   input  logic [WIDTH-1:0]   REQ_OPB,
   input  logic               REQ_CIN,
   output logic [1:0]         INP_VALID,
   output logic               MODE,
   output logic [3:0]         CMD,
   output logic [WIDTH-1:0]   OPA,
   output logic [WIDTH-1:0]   OPB,
   output logic               CIN,
   input  logic [2*WIDTH-1:0] RES,
   input  logic               ERR,
   input  logic               OFLOW,
   input  logic               COUT,
   input  logic               G,
   input  logic               L,
   input  logic               E,
   output logic               RSP_VALID,
   input  logic               RSP_READY,
   output logic [2*WIDTH-1:0] RSP_RES,
   output logic [5:0]         RSP_FLAGS,
   output logic [15:0]        STAT_OPS
);
   typedef enum logic [2:0] {IDLE, SEND_A, ISSUE, WAIT, RESP} state_t;
   typedef struct packed {
      logic             mode;
      logic [3:0]       cmd;
      logic [1:0]       iv;
      logic [3:0]       gap;
      logic [WIDTH-1:0] opa;
      logic [WIDTH-1:0] opb;
      logic             cin;
   } op_t;
   state_t state, state_n;
   op_t req, op, src;
   logic [7:0] cnt, cnt_n, lat_m1;
   logic accept, capture, drive;
   assign req       = {REQ_MODE, REQ_CMD, REQ_IV, REQ_GAP, REQ_OPA, REQ_OPB, REQ_CIN};
   assign src       = state == IDLE ? req : op;
   assign REQ_READY = state == IDLE && CE && !RST;
   assign RSP_VALID = state == RESP;
   assign accept    = REQ_VALID && REQ_READY;
   assign lat_m1    = (op.mode && (op.cmd == 4'd9 || op.cmd == 4'd10)) ? 8'(MUL_LAT - 1) : 8'(LAT - 1);
   assign capture   = state == WAIT && cnt == lat_m1;
   assign drive     = state_n == SEND_A || state_n == ISSUE;
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE:    if (accept) begin
            state_n = req.iv == 2'b00 ? RESP : (req.iv == 2'b11 && req.gap != 4'd0) ? SEND_A : ISSUE;
            cnt_n   = '0;
         end
         SEND_A:  if (cnt == {4'd0, op.gap} - 8'd1) begin
            state_n = ISSUE;
            cnt_n   = '0;
         end else cnt_n = cnt + 8'd1;
         ISSUE:   begin
            state_n = WAIT;
            cnt_n   = '0;
         end
         WAIT:    if (capture) begin
            state_n = RESP;
            cnt_n   = '0;
         end else cnt_n = cnt + 8'd1;
         RESP:    if (RSP_READY) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // ALU-side outputs are registered from the state being entered, so they line up with that state
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         op        <= '0;
         INP_VALID <= '0;
         MODE      <= 1'b0;
         CMD       <= '0;
         OPA       <= '0;
         OPB       <= '0;
         CIN       <= 1'b0;
         RSP_RES   <= '0;
         RSP_FLAGS <= '0;
         STAT_OPS  <= '0;
      end else if (CE) begin
         state     <= state_n;
         cnt       <= cnt_n;
         if (accept) op <= req;
         INP_VALID <= state_n == SEND_A ? 2'b01 : state_n == ISSUE ? src.iv : 2'b00;
         MODE      <= drive && src.mode;
         CMD       <= drive ? src.cmd : 4'd0;
         OPA       <= drive && src.iv[0] ? src.opa : '0;
         OPB       <= state_n == ISSUE && src.iv[1] ? src.opb : '0;
         CIN       <= drive && src.cin;
         if (capture) begin
            RSP_RES   <= RES;
            RSP_FLAGS <= {ERR, OFLOW, COUT, G, L, E};
         end else if (accept && req.iv == 2'b00) begin
            RSP_RES   <= '0;
            RSP_FLAGS <= 6'b100000;
         end
         if (state == RESP && RSP_READY) STAT_OPS <= STAT_OPS + 16'd1;
      end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: drives alu_op_sequencer against a small latency-accurate ALU model;
// responses are checked by a scoreboard queue, timing and side effects by per-scenario tasks.
module tb_alu_op_sequencer;
   logic clk = 0, rst = 1, ce = 1;
   logic req_valid = 0, req_mode = 0, req_cin = 0, rsp_ready = 1;
   logic [3:0] req_cmd = 0, req_gap = 0;
   logic [1:0] req_iv = 0;
   logic [7:0] req_opa = 0, req_opb = 0;
   logic req_ready, mode, cin, rsp_valid;
   logic [1:0] inp_valid;
   logic [3:0] cmd;
   logic [7:0] opa, opb;
   logic [15:0] res, rsp_res, stat_ops;
   logic err, oflow, cout, g, l, e;
   logic [5:0] rsp_flags;
   int compared = 0, mismatched = 0, exp_ops = 0;
   logic [21:0] sb[$];
   logic [21:0] exp_r;
   always #5 clk = ~clk;
   alu_op_sequencer #(.WIDTH(8), .LAT(1), .MUL_LAT(2)) dut (
      .CLK(clk), .RST(rst), .CE(ce), .REQ_VALID(req_valid), .REQ_READY(req_ready),
      .REQ_MODE(req_mode), .REQ_CMD(req_cmd), .REQ_IV(req_iv), .REQ_GAP(req_gap),
      .REQ_OPA(req_opa), .REQ_OPB(req_opb), .REQ_CIN(req_cin),
      .INP_VALID(inp_valid), .MODE(mode), .CMD(cmd), .OPA(opa), .OPB(opb), .CIN(cin),
      .RES(res), .ERR(err), .OFLOW(oflow), .COUT(cout), .G(g), .L(l), .E(e),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RES(rsp_res), .RSP_FLAGS(rsp_flags),
      .STAT_OPS(stat_ops)
   );
   function automatic logic [21:0] alu_fn(input logic m, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b, input logic ci);
      logic [15:0] r;
      r = (m && c == 4'd0) ? {8'h0, a} + {8'h0, b} + {15'h0, ci} :
          (m && (c == 4'd9 || c == 4'd10)) ? {8'h0, a} * {8'h0, b} : {8'h0, a ^ b};
      return {r, 1'b0, 1'b0, r[8], a > b, a < b, a == b};
   endfunction
   // ALU model: result is visible only in the cycle before the correct capture edge, garbage otherwise
   logic armed = 0, alu_mul = 0;
   logic [3:0] alu_k = 0;
   logic [21:0] alu_val = 0;
   always @(posedge clk or posedge rst)
      if (rst) begin
         armed <= 0;
         alu_k <= 0;
      end else if (ce) begin
         if (inp_valid != 2'b00) begin
            armed   <= 1;
            alu_k   <= 0;
            alu_val <= alu_fn(mode, cmd, opa, opb, cin);
            alu_mul <= mode && (cmd == 4'd9 || cmd == 4'd10);
         end else if (armed) alu_k <= alu_k + 4'd1;
      end
   assign {res, err, oflow, cout, g, l, e} = (armed && alu_k == {3'b0, alu_mul}) ? alu_val : {16'hDEAD, 6'b010101};
   always @(negedge clk)
      if (!rst && ce && rsp_valid && rsp_ready) begin
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL rsp_unexpected got=%h required=none", {rsp_res, rsp_flags});
         end else begin
            exp_r = sb.pop_front();
            if ({rsp_res, rsp_flags} !== exp_r) begin
               mismatched++;
               $display("FAIL rsp_data got=%h/%b required=%h/%b", rsp_res, rsp_flags, exp_r[21:6], exp_r[5:0]);
            end
         end
         exp_ops++;
      end
   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic m, input logic [3:0] c, input logic [1:0] iv, input logic [3:0] gp, input logic [7:0] a, input logic [7:0] b, input logic ci);
      int n = 0;
      while (req_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      compared++;
      if (req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL accept_wait req_ready=%b required=1", req_ready);
      end
      {req_mode, req_cmd, req_iv, req_gap, req_opa, req_opb, req_cin} = {m, c, iv, gp, a, b, ci};
      req_valid = 1;
      sb.push_back(iv == 2'b00 ? {16'h0, 6'b100000} : alu_fn(m, c, iv[0] ? a : 8'h0, iv[1] ? b : 8'h0, ci));
      tick();
      req_valid = 0;
   endtask
   task automatic test_reset();
      rst = 1;
      tick();
      tick();
      compared++;
      if ({inp_valid, mode, cmd, opa, opb, cin, rsp_valid, rsp_res, rsp_flags, stat_ops, req_ready} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs got=%h required=0", {inp_valid, mode, cmd, opa, opb, cin, rsp_valid, rsp_res, rsp_flags, stat_ops, req_ready});
      end
      rst = 0;
      #1;
      compared++;
      if (req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_ready got=%b required=1", req_ready);
      end
   endtask
   task automatic test_add();
      send(1, 0, 2'b11, 0, 8'h0F, 8'h01, 0);
      compared++;
      if ({inp_valid, mode, cmd, opa, opb, req_ready, rsp_valid} !== {2'b11, 1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 1'b0}) begin
         mismatched++;
         $display("FAIL add_issue got=%h required=%h", {inp_valid, mode, cmd, opa, opb, req_ready, rsp_valid}, {2'b11, 1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 1'b0});
      end
      tick();
      compared++;
      if ({inp_valid, rsp_valid} !== 3'b000) begin
         mismatched++;
         $display("FAIL add_wait got=%b required=000", {inp_valid, rsp_valid});
      end
      tick();
      compared++;
      if ({rsp_valid, rsp_res} !== {1'b1, 16'h0010}) begin
         mismatched++;
         $display("FAIL add_rsp got=%b/%h required=1/0010", rsp_valid, rsp_res);
      end
      tick();
      compared++;
      if ({rsp_valid, req_ready, stat_ops} !== {1'b0, 1'b1, 16'(exp_ops)}) begin
         mismatched++;
         $display("FAIL add_done got=%b/%b/%0d required=0/1/%0d", rsp_valid, req_ready, stat_ops, exp_ops);
      end
   endtask
   task automatic test_gap();
      send(1, 0, 2'b11, 3, 8'h0F, 8'h01, 0);
      for (int i = 0; i < 3; i++) begin
         compared++;
         if ({inp_valid, opa, opb} !== {2'b01, 8'h0F, 8'h00}) begin
            mismatched++;
            $display("FAIL gap_send_a cycle=%0d got=%h required=%h", i, {inp_valid, opa, opb}, {2'b01, 8'h0F, 8'h00});
         end
         tick();
      end
      compared++;
      if ({inp_valid, opa, opb} !== {2'b11, 8'h0F, 8'h01}) begin
         mismatched++;
         $display("FAIL gap_issue got=%h required=%h", {inp_valid, opa, opb}, {2'b11, 8'h0F, 8'h01});
      end
      tick();
      compared++;
      if (inp_valid !== 2'b00) begin
         mismatched++;
         $display("FAIL gap_wait got=%b required=00", inp_valid);
      end
      tick();
      compared++;
      if ({rsp_valid, rsp_res} !== {1'b1, 16'h0010}) begin
         mismatched++;
         $display("FAIL gap_rsp got=%b/%h required=1/0010", rsp_valid, rsp_res);
      end
      tick();
   endtask
   task automatic test_mul();
      send(1, 9, 2'b11, 0, 8'h03, 8'h04, 0);
      tick();
      tick();
      compared++;
      if (rsp_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL mul_early got=%b required=0", rsp_valid);
      end
      tick();
      compared++;
      if (rsp_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL mul_rsp got=%b required=1", rsp_valid);
      end
      tick();
   endtask
   task automatic test_backpressure();
      logic [21:0] x;
      x = alu_fn(1, 0, 8'h05, 8'h07, 1);
      rsp_ready = 0;
      send(1, 0, 2'b11, 0, 8'h05, 8'h07, 1);
      tick();
      tick();
      {req_valid, req_iv, req_opa} = {1'b1, 2'b11, 8'h99};
      for (int i = 0; i < 5; i++) begin
         compared++;
         if ({rsp_valid, rsp_res, rsp_flags, req_ready, stat_ops} !== {1'b1, x, 1'b0, 16'(exp_ops)}) begin
            mismatched++;
            $display("FAIL bp_hold cycle=%0d got=%h required=%h", i, {rsp_valid, rsp_res, rsp_flags, req_ready, stat_ops}, {1'b1, x, 1'b0, 16'(exp_ops)});
         end
         tick();
      end
      req_valid = 0;
      rsp_ready = 1;
      tick();
      compared++;
      if ({rsp_valid, stat_ops} !== {1'b0, 16'(exp_ops)}) begin
         mismatched++;
         $display("FAIL bp_release got=%b/%0d required=0/%0d", rsp_valid, stat_ops, exp_ops);
      end
   endtask
   task automatic test_partial();
      send(1, 0, 2'b01, 5, 8'hAA, 8'h55, 1);
      compared++;
      if ({inp_valid, opa, opb} !== {2'b01, 8'hAA, 8'h00}) begin
         mismatched++;
         $display("FAIL opa_only got=%h required=%h", {inp_valid, opa, opb}, {2'b01, 8'hAA, 8'h00});
      end
      tick();
      compared++;
      if (inp_valid !== 2'b00) begin
         mismatched++;
         $display("FAIL opa_only_single got=%b required=00", inp_valid);
      end
      tick();
      tick();
      send(0, 4, 2'b10, 0, 8'hAA, 8'h55, 0);
      compared++;
      if ({inp_valid, opa, opb} !== {2'b10, 8'h00, 8'h55}) begin
         mismatched++;
         $display("FAIL opb_only got=%h required=%h", {inp_valid, opa, opb}, {2'b10, 8'h00, 8'h55});
      end
      tick();
      tick();
      tick();
   endtask
   task automatic test_none();
      send(0, 3, 2'b00, 0, 8'h11, 8'h22, 0);
      compared++;
      if ({rsp_valid, rsp_res, rsp_flags, inp_valid} !== {1'b1, 16'h0, 6'b100000, 2'b00}) begin
         mismatched++;
         $display("FAIL none_rsp got=%h required=%h", {rsp_valid, rsp_res, rsp_flags, inp_valid}, {1'b1, 16'h0, 6'b100000, 2'b00});
      end
      tick();
      compared++;
      if ({req_ready, inp_valid} !== 3'b100) begin
         mismatched++;
         $display("FAIL none_done got=%b required=100", {req_ready, inp_valid});
      end
   endtask
   task automatic test_ce();
      send(1, 0, 2'b11, 0, 8'h20, 8'h22, 0);
      tick();
      ce = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         compared++;
         if ({rsp_valid, inp_valid, req_ready} !== 4'b0000) begin
            mismatched++;
            $display("FAIL ce_freeze cycle=%0d got=%b required=0000", i, {rsp_valid, inp_valid, req_ready});
         end
      end
      ce = 1;
      tick();
      compared++;
      if (rsp_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL ce_resume got=%b required=1", rsp_valid);
      end
      tick();
   endtask
   task automatic test_reset_mid();
      send(1, 9, 2'b11, 0, 8'h06, 8'h07, 0);
      tick();
      rst = 1;
      #1;
      compared++;
      if ({inp_valid, mode, cmd, opa, opb, cin, rsp_valid, rsp_res, rsp_flags, stat_ops, req_ready} !== '0) begin
         mismatched++;
         $display("FAIL midreset_outputs got=%h required=0", {inp_valid, mode, cmd, opa, opb, cin, rsp_valid, rsp_res, rsp_flags, stat_ops, req_ready});
      end
      sb.delete();
      exp_ops = 0;
      tick();
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         compared++;
         if ({rsp_valid, inp_valid, stat_ops} !== '0) begin
            mismatched++;
            $display("FAIL midreset_quiet cycle=%0d got=%h required=0", i, {rsp_valid, inp_valid, stat_ops});
         end
      end
   endtask
   task automatic test_back_to_back();
      int n = 0;
      for (int i = 0; i < 24; i++)
         send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      while (sb.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      tick();
      compared++;
      if (sb.size() != 0 || stat_ops !== 16'(exp_ops)) begin
         mismatched++;
         $display("FAIL b2b_drain pending=%0d stat_ops=%0d required=0/%0d", sb.size(), stat_ops, exp_ops);
      end
   endtask
   initial begin
      test_reset();
      test_add();
      test_gap();
      test_mul();
      test_backpressure();
      test_partial();
      test_none();
      test_ce();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
